// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states, reset/NOP constants,
// and opcode values also used by the decoder.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_HALT
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] CPU_NOP_INST     = 32'h0000_0013;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: imem req/ack, core accept, branch info
// and the held-instruction bundle towards the decoder.
interface ifetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        core_ready;
    logic        br_taken;
    logic [31:0] br_offset;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] retire_cnt;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        input  core_ready, br_taken, br_offset,
        output inst, inst_valid, pc_out,
        output retire_cnt, fetch_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        output core_ready, br_taken, br_offset,
        input  inst, inst_valid, pc_out,
        input  retire_cnt, fetch_err
    );

endinterface

// File: rtl/ifetch_unit_pc_next_calc.sv
// Next-PC adder/select: sequential +4 or taken-branch target,
// plus a flag for a target that is not word aligned.
module pc_next_calc (
    input  logic [31:0] i_pc,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_offset,
    output logic [31:0] o_next_pc,
    output logic        o_misalign
);

    logic [31:0] w_incr;

    // pick the increment, then one 32-bit modulo add
    always_comb begin
        w_incr     = i_br_taken ? i_br_offset : 32'd4;
        o_next_pc  = i_pc + w_incr;
        o_misalign = (o_next_pc[1:0] != 2'b00);
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, hold-for-decoder.
// IFETCH_MISALIGN_TRAP_EN: halt with fetch_err on unaligned next PC.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = CPU_NOP_INST
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_inst, w_inst_nxt;
    logic [31:0]  r_cnt, w_cnt_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_err, w_err_nxt;
    logic [31:0]  w_next_pc;
    logic         w_misalign;

    pc_next_calc u_pc_next_calc (
        .i_pc        (r_pc),
        .i_br_taken  (bus.br_taken),
        .i_br_offset (bus.br_offset),
        .o_next_pc   (w_next_pc),
        .o_misalign  (w_misalign)
    );

`ifndef IFETCH_MISALIGN_TRAP_EN
    logic w_unused_misalign;
    assign w_unused_misalign = w_misalign;
`endif

    // state and datapath registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
            r_cnt   <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_valid_nxt = r_valid;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        unique case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (bus.imem_ack) begin
                    w_inst_nxt  = bus.imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.core_ready) begin
                    w_cnt_nxt   = r_cnt + 32'd1;
                    w_valid_nxt = 1'b0;
                    w_inst_nxt  = NOP_INST;
                    w_state_nxt = S_REQ;
`ifdef IFETCH_MISALIGN_TRAP_EN
                    w_pc_nxt    = w_next_pc;
                    if (w_misalign) begin
                        w_state_nxt = S_HALT;
                        w_err_nxt   = 1'b1;
                    end
`else
                    w_pc_nxt    = w_next_pc & ~32'h3;
`endif
                end
            end
            S_HALT: w_state_nxt = S_HALT;
        endcase
    end

    // bus outputs straight from registered state
    always_comb begin
        bus.imem_req   = (r_state == S_REQ);
        bus.imem_addr  = r_pc;
        bus.inst       = r_inst;
        bus.inst_valid = r_valid;
        bus.pc_out     = r_pc;
        bus.retire_cnt = r_cnt;
`ifdef IFETCH_MISALIGN_TRAP_EN
        bus.fetch_err  = r_err;
`else
        bus.fetch_err  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed plan steps plus random traffic
// checked against a transaction-level fetch model.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifetch_unit_if bus ();

    ifetch_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_cnt;
    logic        m_held;
    logic        m_idle;
    logic        m_halt;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic exp_req;
        exp_req = !m_held && !m_idle && !m_halt;
        chk("valid", 32'(bus.inst_valid), 32'(m_held));
        chk("inst", bus.inst, m_held ? m_inst : NOP);
        chk("pc", bus.pc_out, m_pc);
        chk("addr", bus.imem_addr, m_pc);
        chk("req", 32'(bus.imem_req), 32'(exp_req));
        chk("cnt", bus.retire_cnt, m_cnt);
        chk("err", 32'(bus.fetch_err), 32'(m_halt));
    endtask

    // one clock: apply inputs, advance model, check at negedge
    task automatic cyc(input logic r, input logic a,
                       input logic cr, input logic bt,
                       input logic [31:0] d,
                       input logic [31:0] bo);
        logic [31:0] nxt;
        rst            = r;
        bus.imem_ack   = a;
        bus.imem_rdata = d;
        bus.core_ready = cr;
        bus.br_taken   = bt;
        bus.br_offset  = bo;
        if (r) begin
            m_pc   = 32'h0;
            m_held = 1'b0;
            m_idle = 1'b1;
            m_cnt  = 32'h0;
            m_halt = 1'b0;
            m_inst = NOP;
        end else if (m_halt) begin
            m_halt = 1'b1;
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (!m_held) begin
            if (a) begin
                m_held = 1'b1;
                m_inst = d;
            end
        end else if (cr) begin
            nxt    = bt ? m_pc + bo : m_pc + 32'd4;
            m_held = 1'b0;
            m_cnt  = m_cnt + 32'd1;
`ifdef IFETCH_MISALIGN_TRAP_EN
            m_pc = nxt;
            if (nxt[1:0] != 2'b00) m_halt = 1'b1;
`else
            m_pc = nxt & 32'hFFFF_FFFC;
`endif
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic fetch_accept(input logic bt,
                                input logic [31:0] off);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, $urandom, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, bt, 32'h0, off);
    endtask

    initial begin
        logic [31:0] hold_inst;
        logic [31:0] off;
        // plan: reset, one wait state, ack
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst_pc", bus.pc_out, 32'h0);
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wait_addr", bus.imem_addr, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0050_0093, 32'h0);
        chk("tp1_valid", 32'(bus.inst_valid), 32'h1);
        chk("tp1_inst", bus.inst, 32'h0050_0093);
        // sequential accept
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("tp2_addr", bus.imem_addr, 32'h4);
        chk("tp2_cnt", bus.retire_cnt, 32'h1);
        chk("tp2_nop", bus.inst, NOP);
        fetch_accept(1'b0, 32'h0);
        fetch_accept(1'b0, 32'h0);
        fetch_accept(1'b0, 32'h0);
        chk("at_10", bus.pc_out, 32'h10);
        // backward branch, then wrap from top of memory
        fetch_accept(1'b1, 32'hFFFF_FFF8);
        chk("br_back", bus.imem_addr, 32'h8);
        fetch_accept(1'b1, 32'hFFFF_FFF4);
        chk("at_top", bus.pc_out, 32'hFFFF_FFFC);
        fetch_accept(1'b0, 32'h0);
        chk("wrap", bus.imem_addr, 32'h0);
        // stall 5 cycles in hold with stray acks
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE_0013, 32'h0);
        hold_inst = bus.inst;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, $urandom, 32'h40);
            chk("stall_inst", bus.inst, hold_inst);
            chk("stall_req", 32'(bus.imem_req), 32'h0);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("stall_cnt", bus.retire_cnt, 32'd8);
        // reset with coincident ack in S_REQ
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0);
        chk("rack_pc", bus.pc_out, 32'h0);
        chk("rack_valid", 32'(bus.inst_valid), 32'h0);
        chk("rack_req", 32'(bus.imem_req), 32'h0);
        // misaligned branch target
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch_accept(1'b1, 32'h6);
`ifdef IFETCH_MISALIGN_TRAP_EN
        chk("trap_pc", bus.pc_out, 32'h6);
        chk("trap_err", 32'(bus.fetch_err), 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
            chk("trap_noreq", 32'(bus.imem_req), 32'h0);
        end
`else
        chk("align_addr", bus.imem_addr, 32'h4);
        chk("align_err", 32'(bus.fetch_err), 32'h0);
`endif
        // random traffic
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            off = ($urandom_range(0, 63) << 2) - 32'd128;
            if ($urandom % 8 == 0) off = $urandom & 32'hFFFF_FFFC;
`ifndef IFETCH_MISALIGN_TRAP_EN
            off = off | 32'($urandom % 4);
`endif
            cyc(($urandom % 97) == 0,
                ($urandom % 3) == 0,
                ($urandom % 2) == 0,
                ($urandom % 3) == 0,
                $urandom, off);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
